clk_div_ctrl: RTL and testbench

- Runtime-programmable clock divider controller: generates a registered divided clock `div_out` and a one-cycle `tick` enable from `clk_ref`.
- Accepts divisor reconfiguration through a valid/ready handshake and applies it only at a period boundary, so `div_out` never glitches or shortens.
- Sequences start/stop cleanly, so no runt pulse occurs on stop.
- Sits between software/config logic and the peripherals that need slow clocks or clock enables.

---
 rtl/clk_div_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider controller.
// Produces a registered divided clock and a first-cycle-of-period tick from
// clk_ref. A new divisor can be offered through a valid/ready handshake. It
// takes effect only at a period boundary. Stopping always lets the current
// period finish, so the output never emits a runt pulse.
module clk_div_ctrl #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             clk_ref,
    input  logic             srst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             cfg_done,
    output logic [DIV_W-1:0] cur_div,
    output logic             div_out,
    output logic             tick,
    output logic             active
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cur_div_reg;
    logic [DIV_W-1:0] pend_div_reg;
    logic             div_out_reg;
    logic             tick_reg;
    logic             err_reg;
    logic             done_reg;
    logic             ready_reg;
    logic             active_reg;

    logic             last_cycle;
    logic [DIV_W-1:0] cnt_inc;
    logic             inc_high;
    logic             accept;
    logic             cfg_ok;

    // Period bookkeeping and handshake qualification for the current cycle.
    // cnt_reg never exceeds cur_div-1, so cnt_inc cannot overflow.
    always_comb begin
        last_cycle = (cnt_reg == (cur_div_reg - ONE));
        cnt_inc    = cnt_reg + ONE;
        inc_high   = (cnt_inc < (cur_div_reg >> 1));
        accept     = cfg_valid & ready_reg;
        cfg_ok     = (cfg_div >= TWO);
    end

    // Controller FSM; every output is a register updated alongside the counter.
    always_ff @(posedge clk_ref) begin
        if (!srst_n) begin
            state_reg    <= ST_STOP;
            cnt_reg      <= '0;
            cur_div_reg  <= DIV_INIT;
            pend_div_reg <= '0;
            div_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            active_reg   <= 1'b0;
        end else begin
            err_reg  <= accept & ~cfg_ok;
            done_reg <= 1'b0;
            tick_reg <= 1'b0;
            case (state_reg)
                ST_STOP: begin
                    cnt_reg     <= '0;
                    div_out_reg <= 1'b0;
                    // The divisor lands before a same-cycle start, so the
                    // first period already uses it.
                    if (accept && cfg_ok) begin
                        cur_div_reg <= cfg_div;
                        done_reg    <= 1'b1;
                    end
                    if (run) begin
                        state_reg   <= ST_RUN;
                        active_reg  <= 1'b1;
                        tick_reg    <= 1'b1;
                        div_out_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_cycle) begin
                        cnt_reg <= '0;
                        if (run) begin
                            tick_reg    <= 1'b1;
                            div_out_reg <= 1'b1;
                            // A divisor arriving on the wrap waits one full
                            // period; this wrap keeps the old N.
                            if (accept && cfg_ok) begin
                                pend_div_reg <= cfg_div;
                                ready_reg    <= 1'b0;
                                state_reg    <= ST_PEND;
                            end
                        end else begin
                            state_reg   <= ST_STOP;
                            active_reg  <= 1'b0;
                            div_out_reg <= 1'b0;
                            // Stopping on this edge leaves no later boundary,
                            // so a divisor offered now is applied directly.
                            if (accept && cfg_ok) begin
                                cur_div_reg <= cfg_div;
                                done_reg    <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_reg     <= cnt_inc;
                        div_out_reg <= inc_high;
                        if (accept && cfg_ok) begin
                            pend_div_reg <= cfg_div;
                            ready_reg    <= 1'b0;
                            state_reg    <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (last_cycle) begin
                        cnt_reg     <= '0;
                        cur_div_reg <= pend_div_reg;
                        done_reg    <= 1'b1;
                        ready_reg   <= 1'b1;
                        if (run) begin
                            state_reg   <= ST_RUN;
                            tick_reg    <= 1'b1;
                            div_out_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_STOP;
                            active_reg  <= 1'b0;
                            div_out_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg     <= cnt_inc;
                        div_out_reg <= inc_high;
                    end
                end
                default: begin
                    state_reg   <= ST_STOP;
                    cnt_reg     <= '0;
                    div_out_reg <= 1'b0;
                    ready_reg   <= 1'b1;
                    active_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_reg;
    assign cfg_err   = err_reg;
    assign cfg_done  = done_reg;
    assign cur_div   = cur_div_reg;
    assign div_out   = div_out_reg;
    assign tick      = tick_reg;
    assign active    = active_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: table vectors, directed multi-cycle sequences
// and randomized traffic, all checked against a period-level reference model.
module tb_clk_div_ctrl;

    logic       clk_ref;
    logic       srst_n;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       cfg_done;
    logic [7:0] cur_div;
    logic       div_out;
    logic       tick;
    logic       active;

    int vec_cnt = 0;
    int err_cnt = 0;

    clk_div_ctrl #(.DIV_W(8), .DIV_RST(2)) dut (
        .clk_ref   (clk_ref),
        .srst_n    (srst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cfg_done  (cfg_done),
        .cur_div   (cur_div),
        .div_out   (div_out),
        .tick      (tick),
        .active    (active)
    );

    initial begin
        clk_ref = 1'b0;
        forever #5 clk_ref = ~clk_ref;
    end

    // Reference model: a running flag, position inside the current period,
    // the period length and an optional pending length (0 = none).
    bit m_on;
    int m_pos;
    int m_n;
    int m_pend;
    bit m_err;
    bit m_done;

    function automatic void model_step(bit rst_n, bit r, bit v, int d);
        bit acc;
        bit ok;
        if (!rst_n) begin
            m_on = 0; m_pos = 0; m_n = 2; m_pend = 0; m_err = 0; m_done = 0;
            return;
        end
        acc    = v && (m_pend == 0);
        ok     = (d >= 2);
        m_err  = acc && !ok;
        m_done = 0;
        if (!m_on) begin
            if (acc && ok) begin m_n = d; m_done = 1; end
            if (r) begin m_on = 1; m_pos = 0; end
        end else if (m_pos == m_n - 1) begin
            m_pos = 0;
            if (m_pend != 0) begin
                m_n = m_pend; m_pend = 0; m_done = 1;
                if (!r) m_on = 0;
            end else if (!r) begin
                m_on = 0;
                if (acc && ok) begin m_n = d; m_done = 1; end
            end else if (acc && ok) begin
                m_pend = d;
            end
        end else begin
            m_pos = m_pos + 1;
            if (acc && ok) m_pend = d;
        end
    endfunction

    function automatic logic [13:0] pack(logic t, logic dv, logic a, logic rd,
                                         logic e, logic dn, logic [7:0] c);
        return {t, dv, a, rd, e, dn, c};
    endfunction

    function automatic logic [13:0] model_out();
        logic [7:0] n8;
        n8 = 8'(m_n);
        return pack(m_on && m_pos == 0, m_on && (m_pos < m_n / 2), m_on,
                    m_pend == 0, m_err, m_done, n8);
    endfunction

    function automatic logic [13:0] dut_out();
        return pack(tick, div_out, active, cfg_ready, cfg_err, cfg_done, cur_div);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare after the edge.
    task automatic apply(input bit rst_n, input bit r, input bit v, input logic [7:0] d);
        srst_n    = rst_n;
        run       = r;
        cfg_valid = v;
        cfg_div   = d;
        @(posedge clk_ref);
        model_step(rst_n, r, v, int'(d));
        #1;
        check("model", int'(dut_out()), int'(model_out()));
    endtask

    // Let the divider stop at its next boundary, then load divisor n.
    task automatic set_div(input logic [7:0] n);
        int guard;
        guard = 0;
        while (m_on && guard < 600) begin
            apply(1, 0, 0, 8'd0);
            guard++;
        end
        if (m_on) begin
            check("stop_timeout", 1, 0);
            $display("FAIL stop_timeout: model never reached STOP, aborting");
            $fatal(1, "stop timeout");
        end
        apply(1, 0, 1, n);
    endtask

    typedef struct {
        bit         rst_n;
        bit         run;
        bit         valid;
        logic [7:0] div;
        bit         e_tick;
        bit         e_div;
        bit         e_act;
        bit         e_rdy;
        bit         e_err;
        bit         e_done;
        logic [7:0] e_cur;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int hi;
        int tk;
        srst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

        //            rst run vld div    tick dout act rdy err done cur
        tbl[0]  = '{0, 1, 1, 8'd9,   0, 0, 0, 1, 0, 0, 8'd2};
        tbl[1]  = '{1, 1, 0, 8'd0,   1, 1, 1, 1, 0, 0, 8'd2};
        tbl[2]  = '{1, 1, 0, 8'd0,   0, 0, 1, 1, 0, 0, 8'd2};
        tbl[3]  = '{1, 1, 0, 8'd0,   1, 1, 1, 1, 0, 0, 8'd2};
        tbl[4]  = '{1, 1, 1, 8'd0,   0, 0, 1, 1, 1, 0, 8'd2};
        tbl[5]  = '{1, 1, 1, 8'd1,   1, 1, 1, 1, 1, 0, 8'd2};
        tbl[6]  = '{1, 0, 0, 8'd0,   0, 0, 1, 1, 0, 0, 8'd2};
        tbl[7]  = '{1, 0, 0, 8'd0,   0, 0, 0, 1, 0, 0, 8'd2};
        tbl[8]  = '{1, 0, 1, 8'd5,   0, 0, 0, 1, 0, 1, 8'd5};
        tbl[9]  = '{1, 1, 0, 8'd0,   1, 1, 1, 1, 0, 0, 8'd5};
        tbl[10] = '{1, 1, 0, 8'd0,   0, 1, 1, 1, 0, 0, 8'd5};
        tbl[11] = '{1, 1, 0, 8'd0,   0, 0, 1, 1, 0, 0, 8'd5};
        tbl[12] = '{1, 1, 0, 8'd0,   0, 0, 1, 1, 0, 0, 8'd5};
        tbl[13] = '{1, 1, 0, 8'd0,   0, 0, 1, 1, 0, 0, 8'd5};
        tbl[14] = '{1, 1, 0, 8'd0,   1, 1, 1, 1, 0, 0, 8'd5};

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].rst_n, tbl[i].run, tbl[i].valid, tbl[i].div);
            check($sformatf("tbl%0d", i), int'(dut_out()),
                  int'(pack(tbl[i].e_tick, tbl[i].e_div, tbl[i].e_act, tbl[i].e_rdy,
                            tbl[i].e_err, tbl[i].e_done, tbl[i].e_cur)));
        end

        // N=4 running, divisor 7 offered at cnt=1: old period finishes first.
        set_div(8'd4);
        apply(1, 1, 0, 8'd0);                 // cnt 0
        apply(1, 1, 0, 8'd0);                 // cnt 1
        apply(1, 1, 1, 8'd7);                 // cnt 2, now pending
        check("pend_ready_c2", int'(cfg_ready), 0);
        check("pend_cur_c2", int'(cur_div), 4);
        apply(1, 1, 1, 8'd3);                 // cnt 3, offer ignored
        check("pend_ready_c3", int'(cfg_ready), 0);
        check("pend_div_c3", int'(div_out), 0);
        apply(1, 1, 0, 8'd0);                 // switch boundary
        check("switch_done", int'({cfg_done, tick, cfg_ready}), 3'b111);
        check("switch_cur", int'(cur_div), 7);
        hi = int'(div_out);
        for (int k = 0; k < 6; k++) begin
            apply(1, 1, 0, 8'd0);
            hi += int'(div_out);
        end
        check("n7_high", hi, 3);
        apply(1, 1, 0, 8'd0);
        check("n7_wrap_tick", int'(tick), 1);

        // N=6, run dropped at cnt=2: period runs to cnt=5 then stops clean.
        set_div(8'd6);
        apply(1, 1, 0, 8'd0);
        apply(1, 1, 0, 8'd0);
        apply(1, 1, 0, 8'd0);                 // cnt 2
        check("n6_c2_high", int'(div_out), 1);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 8'd0);
            check($sformatf("drain_%0d", k), int'({active, div_out, tick}), 3'b100);
        end
        apply(1, 0, 0, 8'd0);
        check("stopped", int'({active, div_out, tick}), 3'b000);

        // N=9, reset mid-period, then the widest divisor.
        set_div(8'd9);
        apply(1, 1, 0, 8'd0);
        apply(1, 1, 0, 8'd0);
        apply(1, 1, 0, 8'd0);
        apply(0, 1, 1, 8'd200);
        check("rst_outs", int'({div_out, active, tick, cfg_ready}), 4'b0001);
        check("rst_cur", int'(cur_div), 2);
        apply(1, 0, 1, 8'd255);
        check("cfg255_done", int'({cfg_done, cur_div}), int'({1'b1, 8'd255}));
        apply(1, 1, 0, 8'd0);
        hi = int'(div_out);
        tk = int'(tick);
        for (int k = 0; k < 254; k++) begin
            apply(1, 1, 0, 8'd0);
            hi += int'(div_out);
            tk += int'(tick);
        end
        check("n255_high", hi, 127);
        check("n255_ticks", tk, 1);
        apply(1, 1, 0, 8'd0);
        check("n255_wrap", int'({tick, div_out}), 2'b11);

        // Randomized traffic against the model.
        begin
            bit r;
            r = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                bit v;
                bit rn;
                logic [7:0] d;
                if ($urandom_range(0, 39) == 0) r = ~r;
                v  = ($urandom_range(0, 11) == 0);
                d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 12));
                rn = ($urandom_range(0, 699) != 0);
                // Skip offering a divisor on the very edge that stops a period.
                if (m_on && m_pend == 0 && m_pos == m_n - 1 && !r) v = 1'b0;
                apply(rn, r, v, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
